// File: rtl/led_scanner.sv
// Animated LED bar: a lit head steps across WIDTH LEDs at a programmable rate,
// with bounce/wrap/hold motion and a PWM-dimmed trail of recent head positions.
module led_scanner #(
    parameter int WIDTH          = 8,
    parameter int PERIOD_W       = 32,
    parameter int DEFAULT_PERIOD = 1200000,
    parameter int TAIL           = 3,
    parameter int PWM_BITS       = 4,
    localparam int POS_W         = $clog2(WIDTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic [PERIOD_W-1:0] period,
    input  logic                period_load,
    output logic [WIDTH-1:0]    leds,
    output logic [POS_W-1:0]    pos,
    output logic                dir,
    output logic                step
);

    typedef enum logic [1:0] {
        MODE_BOUNCE  = 2'd0,
        MODE_WRAP_UP = 2'd1,
        MODE_WRAP_DN = 2'd2,
        MODE_HOLD    = 2'd3
    } mode_e;

    localparam int TN = (TAIL > 0) ? TAIL : 1;
    localparam logic [POS_W-1:0]    LAST_POS  = POS_W'(WIDTH - 1);
    localparam logic [PERIOD_W-1:0] RST_PERIOD = PERIOD_W'(DEFAULT_PERIOD);

    logic [PERIOD_W-1:0] timer_q, timer_d, period_q;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic                dir_q, dir_d;
    logic                step_q, step_evt;
    logic [PWM_BITS-1:0] pwm_q;
    logic [WIDTH-1:0]    leds_q, leds_d;
    logic [TN:1]         trail_vld_q;
    logic [POS_W-1:0]    trail_idx_q [1:TN];
    logic [TN:1]         trail_on;

    always_comb begin
        step_evt = en && (timer_q == '0);
        timer_d  = timer_q;
        if (en) begin
            timer_d = step_evt ? period_q : timer_q - PERIOD_W'(1);
        end
    end

    // Ends are compared explicitly so a non-power-of-two WIDTH never overshoots.
    always_comb begin
        pos_d = pos_q;
        dir_d = dir_q;
        case (mode_e'(mode))
            MODE_BOUNCE: begin
                if (!dir_q) begin
                    if (pos_q == LAST_POS) begin
                        pos_d = LAST_POS - POS_W'(1);
                        dir_d = 1'b1;
                    end else begin
                        pos_d = pos_q + POS_W'(1);
                    end
                end else begin
                    if (pos_q == '0) begin
                        pos_d = POS_W'(1);
                        dir_d = 1'b0;
                    end else begin
                        pos_d = pos_q - POS_W'(1);
                    end
                end
            end
            MODE_WRAP_UP: begin
                dir_d = 1'b0;
                pos_d = (pos_q == LAST_POS) ? '0 : pos_q + POS_W'(1);
            end
            MODE_WRAP_DN: begin
                dir_d = 1'b1;
                pos_d = (pos_q == '0) ? LAST_POS : pos_q - POS_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_q  <= RST_PERIOD;
            period_q <= RST_PERIOD;
            pos_q    <= '0;
            dir_q    <= 1'b0;
            step_q   <= 1'b0;
            pwm_q    <= '0;
            leds_q   <= '0;
        end else begin
            // A load coinciding with a reload only affects the following reload.
            if (period_load) begin
                period_q <= period;
            end
            timer_q <= timer_d;
            step_q  <= step_evt;
            pwm_q   <= pwm_q + PWM_BITS'(1);
            leds_q  <= leds_d;
            if (step_evt) begin
                pos_q <= pos_d;
                dir_q <= dir_d;
            end
        end
    end

    generate
        if (TAIL > 0) begin : g_trail
            for (genvar gi = 1; gi <= TAIL; gi++) begin : g_stage
                localparam int LEVEL = (1 << PWM_BITS) >> gi;
                if (gi == 1) begin : g_first
                    always_ff @(posedge clk or negedge rst) begin
                        if (!rst) begin
                            trail_vld_q[gi] <= 1'b0;
                            trail_idx_q[gi] <= '0;
                        end else if (step_evt) begin
                            trail_vld_q[gi] <= 1'b1;
                            trail_idx_q[gi] <= pos_q;
                        end
                    end
                end else begin : g_next
                    always_ff @(posedge clk or negedge rst) begin
                        if (!rst) begin
                            trail_vld_q[gi] <= 1'b0;
                            trail_idx_q[gi] <= '0;
                        end else if (step_evt) begin
                            trail_vld_q[gi] <= trail_vld_q[gi-1];
                            trail_idx_q[gi] <= trail_idx_q[gi-1];
                        end
                    end
                end
                // Each older stage gets half the duty of the one before it.
                assign trail_on[gi] = trail_vld_q[gi] &&
                                      ({1'b0, pwm_q} < (PWM_BITS + 1)'(LEVEL));
            end
        end else begin : g_no_trail
            assign trail_vld_q    = '0;
            assign trail_idx_q[1] = '0;
            assign trail_on       = '0;
        end

        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_led
            logic hit;
            always_comb begin
                hit = (pos_q == POS_W'(gi));
                for (int k = 1; k <= TAIL; k++) begin
                    if (trail_on[k] && (trail_idx_q[k] == POS_W'(gi))) begin
                        hit = 1'b1;
                    end
                end
            end
            assign leds_d[gi] = hit;
        end
    endgenerate

    assign leds = leds_q;
    assign pos  = pos_q;
    assign dir  = dir_q;
    assign step = step_q;

endmodule

// File: tb/tb_led_scanner.sv
// Bench for led_scanner: two instances (no trail / 3-deep trail) share stimulus and
// are compared every cycle against a step-level reference model.
module tb_led_scanner;

    localparam int W  = 8;
    localparam int PW = 32;
    localparam int DP = 3;
    localparam int PB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b1;
    logic [1:0]    mode = 2'd0;
    logic [PW-1:0] period = '0;
    logic          period_load = 1'b0;

    logic [W-1:0] leds0, leds1;
    logic [2:0]   pos0, pos1;
    logic         dir0, dir1, step0, step1;

    always #5 clk = ~clk;

    led_scanner #(.WIDTH(W), .PERIOD_W(PW), .DEFAULT_PERIOD(DP), .TAIL(0), .PWM_BITS(PB)) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .period(period), .period_load(period_load),
        .leds(leds0), .pos(pos0), .dir(dir0), .step(step0)
    );

    led_scanner #(.WIDTH(W), .PERIOD_W(PW), .DEFAULT_PERIOD(DP), .TAIL(3), .PWM_BITS(PB)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .period(period), .period_load(period_load),
        .leds(leds1), .pos(pos1), .dir(dir1), .step(step1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: enabled cycles since last step, interval length in force,
    // head position/direction and the list of previous head positions (newest first).
    int m_since, m_len, m_period, m_pos, m_dir, m_step, m_pwm;
    int m_hist[$];
    logic [W-1:0] m_leds0, m_leds1;

    typedef struct {
        logic [1:0] mode;
        int         exp_pos;
        logic       exp_dir;
        int         exp_gap;
    } vec_t;

    vec_t vecs[33];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_since  = 0;
        m_len    = DP;
        m_period = DP;
        m_pos    = 0;
        m_dir    = 0;
        m_step   = 0;
        m_pwm    = 0;
        m_leds0  = '0;
        m_leds1  = '0;
        m_hist.delete();
    endfunction

    function automatic logic [W-1:0] view(input int tail);
        logic [W-1:0] v;
        v = '0;
        v[m_pos] = 1'b1;
        for (int k = 1; k <= tail; k++) begin
            if (k <= m_hist.size() && m_pwm < ((1 << PB) >> k)) v[m_hist[k-1]] = 1'b1;
        end
        return v;
    endfunction

    task automatic cycle();
        int np, nd;
        bit fire;
        m_leds0 = view(0);
        m_leds1 = view(3);
        fire = 0;
        if (en) begin
            if (m_since == m_len) fire = 1;
            else m_since++;
        end
        if (fire) begin
            m_hist.push_front(m_pos);
            if (m_hist.size() > 3) void'(m_hist.pop_back());
            np = m_pos;
            nd = m_dir;
            case (mode)
                2'd0: begin
                    np = (m_dir != 0) ? m_pos - 1 : m_pos + 1;
                    if (np < 0) begin np = 1; nd = 0; end
                    else if (np > W - 1) begin np = W - 2; nd = 1; end
                end
                2'd1: begin np = (m_pos + 1) % W; nd = 0; end
                2'd2: begin np = (m_pos + W - 1) % W; nd = 1; end
                default: ;
            endcase
            m_pos = np;
            m_dir = nd;
            m_since = 0;
            m_len = m_period;
        end
        if (period_load) m_period = int'(period);
        m_step = fire ? 1 : 0;
        m_pwm = (m_pwm + 1) % (1 << PB);
        @(posedge clk);
        #1;
        check("pos", 64'(pos0), 64'(m_pos));
        check("pos_tail", 64'(pos1), 64'(m_pos));
        check("dir", 64'(dir0), 64'(m_dir));
        check("step", 64'(step0), 64'(m_step));
        check("step_tail", 64'(step1), 64'(m_step));
        check("leds", 64'(leds0), 64'(m_leds0));
        check("leds_tail", 64'(leds1), 64'(m_leds1));
    endtask

    task automatic wait_step(output int gap);
        gap = 0;
        do begin
            cycle();
            gap++;
        end while (step0 !== 1'b1 && gap < 200);
        check("step_seen", 64'(step0), 64'd1);
    endtask

    function automatic void add_vec(input int i, input logic [1:0] md, input int p, input logic d);
        vecs[i].mode    = md;
        vecs[i].exp_pos = p;
        vecs[i].exp_dir = d;
        vecs[i].exp_gap = DP + 1;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, cnt, keep;
        int bit_cnt[W];
        int exp_cnt[W];
        int idx;

        idx = 0;
        for (int p = 1; p <= 7; p++) begin add_vec(idx, 2'd0, p, 1'b0); idx++; end
        for (int p = 6; p >= 0; p--) begin add_vec(idx, 2'd0, p, 1'b1); idx++; end
        for (int p = 1; p <= 6; p++) begin add_vec(idx, 2'd0, p, 1'b0); idx++; end
        add_vec(idx, 2'd1, 7, 1'b0); idx++;
        add_vec(idx, 2'd1, 0, 1'b0); idx++;
        add_vec(idx, 2'd1, 1, 1'b0); idx++;
        add_vec(idx, 2'd2, 0, 1'b1); idx++;
        add_vec(idx, 2'd2, 7, 1'b1); idx++;
        add_vec(idx, 2'd2, 6, 1'b1); idx++;
        for (int r = 0; r < 5; r++) begin add_vec(idx, 2'd3, 6, 1'b1); idx++; end
        add_vec(idx, 2'd0, 5, 1'b1); idx++;
        add_vec(idx, 2'd0, 4, 1'b1); idx++;

        // Reset state
        #2 rst = 1'b0;
        #2;
        model_reset();
        check("rst_leds", 64'(leds0), 64'd0);
        check("rst_leds_tail", 64'(leds1), 64'd0);
        check("rst_pos", 64'(pos0), 64'd0);
        check("rst_dir", 64'(dir0), 64'd0);
        check("rst_step", 64'(step0), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("leds_before_edge", 64'(leds0), 64'd0);

        // Directed step table: bounce sweep, wrap-up, wrap-down, hold, bounce resume
        for (int i = 0; i < 33; i++) begin
            mode = vecs[i].mode;
            wait_step(g);
            check("vec_pos", 64'(pos0), 64'(vecs[i].exp_pos));
            check("vec_dir", 64'(dir0), 64'(vecs[i].exp_dir));
            check("vec_gap", 64'(g), 64'(vecs[i].exp_gap));
            $display("vec %0d: mode %0d pos %0d dir %0d gap %0d", i, mode, pos0, dir0, g);
        end

        // Period 0 loaded mid-count: old countdown finishes, then a step every cycle
        cycle();
        period = 0;
        period_load = 1'b1;
        cycle();
        period_load = 1'b0;
        wait_step(g);
        check("reload_gap", 64'(g), 64'd2);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (step0 === 1'b1) cnt++;
        end
        check("fast_steps", 64'(cnt), 64'd5);

        // Load coinciding with a reload: old value (0) used once more
        period = 2;
        period_load = 1'b1;
        cycle();
        period_load = 1'b0;
        wait_step(g);
        check("coincide_gap1", 64'(g), 64'd1);
        wait_step(g);
        check("coincide_gap2", 64'(g), 64'd3);

        // en gating
        cycle();
        keep = m_pos;
        en = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (step0 === 1'b1) cnt++;
        end
        check("gated_steps", 64'(cnt), 64'd0);
        check("gated_pos", 64'(pos0), 64'(keep));
        en = 1'b1;
        wait_step(g);
        check("resume_gap", 64'(g), 64'd2);

        // Asynchronous reset between edges at pos 4
        cnt = 0;
        while (m_pos != 4 && cnt < 100) begin
            cycle();
            cnt++;
        end
        check("reached_pos4", 64'(pos0), 64'd4);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("async_leds", 64'(leds0), 64'd0);
        check("async_leds_tail", 64'(leds1), 64'd0);
        check("async_pos", 64'(pos0), 64'd0);
        check("async_dir", 64'(dir0), 64'd0);
        check("async_step", 64'(step0), 64'd0);
        @(posedge clk);
        #1;
        check("held_pos", 64'(pos0), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        mode = 2'd0;
        wait_step(g);
        check("restart_gap", 64'(g), 64'(DP + 1));
        check("restart_pos", 64'(pos0), 64'd1);
        cycle();
        check("restart_leds", 64'(leds0), 64'h02);

        // Trail dimming: head at 5 moving up, trail 4,3,2, animation frozen
        for (int i = 0; i < 4; i++) wait_step(g);
        check("tail_head", 64'(pos1), 64'd5);
        en = 1'b0;
        cycle();
        for (int b = 0; b < W; b++) begin bit_cnt[b] = 0; exp_cnt[b] = 0; end
        exp_cnt[5] = 16; exp_cnt[4] = 8; exp_cnt[3] = 4; exp_cnt[2] = 2;
        for (int i = 0; i < 16; i++) begin
            cycle();
            for (int b = 0; b < W; b++) if (leds1[b] === 1'b1) bit_cnt[b]++;
        end
        for (int b = 0; b < W; b++) check($sformatf("duty_bit%0d", b), 64'(bit_cnt[b]), 64'(exp_cnt[b]));
        en = 1'b1;

        // Randomized run against the model
        for (int i = 0; i < 600; i++) begin
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            period = PW'($urandom_range(0, 5));
            period_load = ($urandom_range(0, 19) == 0);
            cycle();
        end
        period_load = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
